// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, datapath mux selects, ALUOp classes and trap causes.
package ctrl_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL,
        S_AUIPC,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_U     = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // funct3 values that steer the ALU decoder's ALUOp=11 sub-cases
    localparam logic [2:0] F3_FORCE_AUIPC = 3'b000;
    localparam logic [2:0] F3_FORCE_LUI   = 3'b001;

    // State that follows DECODE for a given opcode; unknown opcodes trap.
    function automatic state_t decode_target(input logic [6:0] op);
        state_t s;
        case (op)
            OP_LOAD, OP_STORE: s = S_MEMADR;
            OP_R:              s = S_EXEC_R;
            OP_I:              s = S_EXEC_I;
            OP_BRANCH:         s = S_BRANCH;
            OP_JAL:            s = S_JAL;
            OP_JALR:           s = S_JALR;
            OP_AUIPC:          s = S_AUIPC;
            OP_LUI:            s = S_LUI;
            default:           s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       f3_force_en;
    logic [2:0] f3_force;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, f3_force_en, f3_force,
               retire, trap, trap_cause
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, f3_force_en, f3_force,
               retire, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Immediate-format select, decoded straight from the opcode in every state.
module imm_src_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [2:0] o_imm_src
);

    // Opcode to immediate format; R-type and unknown opcodes fall back to I.
    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_STORE:          o_imm_src = IMM_S;
            OP_BRANCH:         o_imm_src = IMM_B;
            OP_JAL:            o_imm_src = IMM_J;
            OP_AUIPC, OP_LUI:  o_imm_src = IMM_U;
            default:           o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core, with memory wait watchdog
// and sticky trap on illegal opcodes / memory timeouts.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    multicycle_controller_if.master bus
);

    if (STATE_W != STATE_BITS) begin : g_state_w_check
        $error("STATE_W does not match the state encoding width");
    end
    if ((64'd1 << WAIT_W) <= 64'(MAX_WAIT)) begin : g_wait_w_check
        $error("WAIT_W too narrow for MAX_WAIT");
    end

    // Counter value on the last tolerated wait cycle; used only when MAX_WAIT != 0.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_next;
    logic [2:0]        w_imm_src;
    logic              w_in_wait_state;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_branch_legal;

    imm_src_decoder u_imm_src_decoder (
        .i_op      (bus.op),
        .o_imm_src (w_imm_src)
    );

    assign w_in_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                             (r_state == S_MEMWRITE);
    assign w_waiting       = w_in_wait_state && !bus.mem_ready;
    assign w_timeout       = (MAX_WAIT != 0) && w_waiting && (r_wait == WAIT_LAST);
    assign w_branch_legal  = (bus.funct3 == F3_BEQ) || (bus.funct3 == F3_BNE);

    // State, trap cause and saturating wait counter (cleared on every state change).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_cause <= TRAP_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting && (r_wait != '1)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    // Next state; mem_ready on the timeout cycle takes priority over the trap.
    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        case (r_state)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    w_next = (r_state == S_FETCH)   ? S_DECODE :
                             (r_state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
                end else if (w_timeout) begin
                    w_next       = S_TRAP;
                    w_cause_next = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                w_next = decode_target(bus.op);
                if (w_next == S_TRAP) w_cause_next = TRAP_ILLEGAL;
            end
            S_MEMADR:                          w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMWB, S_ALUWB:                  w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_AUIPC, S_LUI: w_next = S_ALUWB;
            S_BRANCH: begin
                if (w_branch_legal) begin
                    w_next = S_FETCH;
                end else begin
                    w_next       = S_TRAP;
                    w_cause_next = TRAP_ILLEGAL;
                end
            end
            S_JALR:  w_next = S_JAL;
            S_JAL:   w_next = S_ALUWB;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Moore output decode; strobes are forced low while reset is asserted.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.adr_src     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.result_src  = RES_ALUOUT;
        bus.alu_src_a   = SRCA_PC;
        bus.alu_src_b   = SRCB_RS2;
        bus.alu_op      = ALUOP_ADD;
        bus.imm_src     = w_imm_src;
        bus.f3_force_en = 1'b0;
        bus.f3_force    = 3'b000;
        bus.retire      = 1'b0;
        bus.trap        = (r_state == S_TRAP);
        bus.trap_cause  = r_cause;
        case (r_state)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALU;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = RES_RDATA;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                bus.retire    = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALUOP_SUB;
                bus.pc_write  = ((bus.funct3 == F3_BEQ) && bus.zero) ||
                                ((bus.funct3 == F3_BNE) && !bus.zero);
                bus.retire    = w_branch_legal;
            end
            S_JALR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                bus.pc_write  = 1'b1;
            end
            S_AUIPC, S_LUI: begin
                bus.alu_src_a   = SRCA_OLDPC;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_op      = ALUOP_U;
                bus.f3_force_en = 1'b1;
                bus.f3_force    = (r_state == S_LUI) ? F3_FORCE_LUI : F3_FORCE_AUIPC;
            end
            default: ;
        endcase
        if (reset) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: instruction-level script expands each instruction into
// expected per-cycle controls; one checker compares them with the DUT.
module tb_multicycle_controller;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_LUI    = 7'b0110111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       f3e;
        logic [2:0] f3f;
        logic       retire;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.STATE_W(4), .MAX_WAIT(16), .WAIT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    out_t cur_exp, cur_mask;
    string cur_name = "none";
    bit cur_valid = 1'b0;
    logic [6:0] cur_op = 7'b0;
    logic [2:0] cur_f3 = 3'b0;
    logic [1:0] m_cause = 2'b00;
    int force_zero = -1;
    int cnt_adr1 = 0, cnt_retire = 0, cnt_pcw = 0;
    logic [2:0] last_f3f = 3'b111;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == T_STORE) return 3'b001;
        if (op == T_BRANCH) return 3'b010;
        if (op == T_JAL) return 3'b011;
        if (op == T_AUIPC || op == T_LUI) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {T_LOAD, T_STORE, T_R, T_I, T_BRANCH, T_JAL, T_JALR, T_AUIPC, T_LUI};
    endfunction

    function automatic out_t mk(input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] alu, input logic [1:0] res);
        out_t o = '0;
        o.imm_src = imm_of(cur_op);
        o.cause = m_cause;
        o.src_a = a;
        o.src_b = b;
        o.alu_op = alu;
        o.result_src = res;
        return o;
    endfunction

    function automatic out_t fetch_o(input logic mr);
        out_t o = mk(2'b00, 2'b10, 2'b00, 2'b10);
        o.ir_write = mr;
        o.pc_write = mr;
        return o;
    endfunction

    function automatic out_t aluwb_o();
        out_t o = mk(2'b00, 2'b00, 2'b00, 2'b00);
        o.reg_write = 1'b1;
        o.retire = 1'b1;
        return o;
    endfunction

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    // The one per-cycle compare process, 2 time units after the driving edge.
    always @(negedge clk) begin
        out_t act;
        #2;
        if (cur_valid) begin
            act = '{bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                    bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src,
                    bus.f3_force_en, bus.f3_force, bus.retire, bus.trap, bus.trap_cause};
            checks++;
            if ((act & cur_mask) !== (cur_exp & cur_mask)) begin
                failures++;
                $display("FAIL %s t=%0t act=%h req=%h mask=%h", cur_name, $time, act, cur_exp, cur_mask);
            end
            if (act.adr_src) cnt_adr1++;
            if (act.retire) cnt_retire++;
            if (act.pc_write) cnt_pcw++;
            if (act.f3e) last_f3f = act.f3f;
        end
    end

    task automatic cyc(input string nm, input logic mr, input logic z, input out_t e);
        @(negedge clk);
        reset = 1'b0;
        bus.op = cur_op;
        bus.funct3 = cur_f3;
        bus.mem_ready = mr;
        bus.zero = z;
        cur_exp = e;
        cur_mask = '1;
        cur_name = nm;
        cur_valid = 1'b1;
        #3;
    endtask

    task automatic rst_cyc(input logic mr);
        out_t sm = '0;
        sm.pc_write = 1'b1; sm.mem_write = 1'b1; sm.ir_write = 1'b1;
        sm.reg_write = 1'b1; sm.retire = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        bus.op = cur_op;
        bus.funct3 = cur_f3;
        bus.mem_ready = mr;
        bus.zero = rz();
        cur_exp = '0;
        cur_mask = sm;
        cur_name = "reset_strobes";
        cur_valid = 1'b1;
        m_cause = 2'b00;
        #3;
    endtask

    task automatic trap_cycles(input int n);
        out_t e;
        e = mk(2'b00, 2'b00, 2'b00, 2'b00);
        e.trap = 1'b1;
        repeat (n) cyc("trap_hold", rz(), rz(), e);
    endtask

    task automatic clear_counts();
        cnt_adr1 = 0; cnt_retire = 0; cnt_pcw = 0; last_f3f = 3'b111;
    endtask

    // Expand one instruction into its expected cycles, driving waits and zero.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                             input int mw, input bit fto, input bit mto, output bit trapped);
        out_t e;
        logic z;
        cur_op = op;
        cur_f3 = f3;
        trapped = 1'b0;
        if (fto) begin
            repeat (16) cyc("fetch_wait", 1'b0, rz(), fetch_o(1'b0));
            m_cause = 2'b10;
            trapped = 1'b1;
            return;
        end
        repeat (fw) cyc("fetch_wait", 1'b0, rz(), fetch_o(1'b0));
        cyc("fetch", 1'b1, rz(), fetch_o(1'b1));
        cyc("decode", rz(), rz(), mk(2'b01, 2'b01, 2'b00, 2'b00));
        if (!legal_op(op)) begin
            m_cause = 2'b01;
            trapped = 1'b1;
            return;
        end
        if (op == T_LOAD || op == T_STORE) begin
            cyc("memadr", rz(), rz(), mk(2'b10, 2'b01, 2'b00, 2'b00));
            e = mk(2'b00, 2'b00, 2'b00, 2'b00);
            e.adr_src = 1'b1;
            e.mem_write = (op == T_STORE);
            repeat (mto ? 16 : mw) cyc("mem_wait", 1'b0, rz(), e);
            if (mto) begin
                m_cause = 2'b10;
                trapped = 1'b1;
                return;
            end
            e.retire = (op == T_STORE);
            cyc("mem_done", 1'b1, rz(), e);
            if (op == T_LOAD) begin
                e = mk(2'b00, 2'b00, 2'b00, 2'b01);
                e.reg_write = 1'b1;
                e.retire = 1'b1;
                cyc("memwb", rz(), rz(), e);
            end
        end else if (op == T_BRANCH) begin
            z = (force_zero < 0) ? rz() : 1'(force_zero);
            e = mk(2'b10, 2'b00, 2'b01, 2'b00);
            if (f3 == 3'b000 || f3 == 3'b001) begin
                e.pc_write = (f3 == 3'b000) ? z : ~z;
                e.retire = 1'b1;
                cyc("branch", rz(), z, e);
            end else begin
                cyc("branch_bad", rz(), z, e);
                m_cause = 2'b01;
                trapped = 1'b1;
            end
        end else begin
            case (op)
                T_R:     cyc("exec_r", rz(), rz(), mk(2'b10, 2'b00, 2'b10, 2'b00));
                T_I:     cyc("exec_i", rz(), rz(), mk(2'b10, 2'b01, 2'b10, 2'b00));
                T_AUIPC, T_LUI: begin
                    e = mk(2'b01, 2'b01, 2'b11, 2'b00);
                    e.f3e = 1'b1;
                    e.f3f = (op == T_LUI) ? 3'b001 : 3'b000;
                    cyc("upper", rz(), rz(), e);
                end
                default: begin
                    if (op == T_JALR) cyc("jalr", rz(), rz(), mk(2'b10, 2'b01, 2'b00, 2'b00));
                    e = mk(2'b01, 2'b10, 2'b00, 2'b00);
                    e.pc_write = 1'b1;
                    cyc("jal", rz(), rz(), e);
                end
            endcase
            cyc("aluwb", rz(), rz(), aluwb_o());
        end
    endtask

    task automatic recover();
        trap_cycles($urandom_range(1, 3));
        rst_cyc(rz());
    endtask

    function automatic int pick_wait();
        int r = $urandom_range(0, 9);
        if (r < 7) return r % 4;
        return (r == 9) ? 15 : 1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit tr;
        out_t e;
        logic [6:0] op;
        logic [2:0] f3;
        int cls;
        bus.op = '0; bus.funct3 = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        rst_cyc(1'b1);
        rst_cyc(1'b1);

        // add x3,x1,x2 with memory always ready
        clear_counts();
        run_instr(T_R, 3'b000, 0, 0, 0, 0, tr);
        chk("add_retire_pulses", 32'(cnt_retire), 32'd1);
        chk("add_pc_writes", 32'(cnt_pcw), 32'd1);

        // lw, three wait cycles in MEMREAD
        clear_counts();
        run_instr(T_LOAD, 3'b010, 0, 3, 0, 0, tr);
        chk("lw_adr_src_cycles", 32'(cnt_adr1), 32'd4);
        chk("lw_retire_pulses", 32'(cnt_retire), 32'd1);

        // beq taken, not taken, then an illegal funct3
        force_zero = 1;
        clear_counts();
        run_instr(T_BRANCH, 3'b000, 0, 0, 0, 0, tr);
        chk("beq_taken_pc_writes", 32'(cnt_pcw), 32'd2);
        force_zero = 0;
        clear_counts();
        run_instr(T_BRANCH, 3'b000, 0, 0, 0, 0, tr);
        chk("beq_not_taken_pc_writes", 32'(cnt_pcw), 32'd1);
        force_zero = 1;
        clear_counts();
        run_instr(T_BRANCH, 3'b100, 0, 0, 0, 0, tr);
        trap_cycles(2);
        chk("bad_branch_trap", 32'(bus.trap), 32'd1);
        chk("bad_branch_cause", 32'(bus.trap_cause), 32'd1);
        chk("bad_branch_pc_writes", 32'(cnt_pcw), 32'd1);
        force_zero = -1;
        rst_cyc(1'b0);

        // lui, auipc, jalr
        run_instr(T_LUI, 3'b000, 0, 0, 0, 0, tr);
        chk("lui_f3_force", 32'(last_f3f), 32'd1);
        run_instr(T_AUIPC, 3'b000, 0, 0, 0, 0, tr);
        chk("auipc_f3_force", 32'(last_f3f), 32'd0);
        clear_counts();
        run_instr(T_JALR, 3'b000, 0, 0, 0, 0, tr);
        chk("jalr_pc_writes", 32'(cnt_pcw), 32'd2);

        // fetch timeout after 16 wait cycles, then ready on the 16th cycle
        run_instr(T_R, 3'b000, 0, 0, 1, 0, tr);
        trap_cycles(2);
        chk("timeout_cause", 32'(bus.trap_cause), 32'd2);
        rst_cyc(1'b0);
        clear_counts();
        run_instr(T_R, 3'b000, 15, 0, 0, 0, tr);
        chk("late_ready_no_trap", 32'(bus.trap), 32'd0);
        chk("late_ready_retired", 32'(cnt_retire), 32'd1);

        // reset asserted while a store is waiting in MEMWRITE
        cur_op = T_STORE;
        cur_f3 = 3'b010;
        cyc("fetch", 1'b1, 1'b0, fetch_o(1'b1));
        cyc("decode", 1'b0, 1'b0, mk(2'b01, 2'b01, 2'b00, 2'b00));
        cyc("memadr", 1'b0, 1'b0, mk(2'b10, 2'b01, 2'b00, 2'b00));
        e = mk(2'b00, 2'b00, 2'b00, 2'b00);
        e.adr_src = 1'b1;
        e.mem_write = 1'b1;
        cyc("memwrite_wait", 1'b0, 1'b0, e);
        clear_counts();
        rst_cyc(1'b1);
        chk("reset_abandon_retire", 32'(cnt_retire), 32'd0);
        run_instr(7'b0000000, 3'b000, 1, 0, 0, 0, tr);
        trap_cycles(1);
        chk("zero_op_cause", 32'(bus.trap_cause), 32'd1);
        rst_cyc(1'b0);

        // randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            cls = $urandom_range(0, 19);
            f3 = 3'($urandom_range(0, 7));
            case (cls)
                0, 1:   op = T_LOAD;
                2, 3:   op = T_STORE;
                7, 8, 9: op = T_I;
                10, 11: begin
                    op = T_BRANCH;
                    if ($urandom_range(0, 5) != 0) f3 = 3'($urandom_range(0, 1));
                end
                12:     op = T_JAL;
                13:     op = T_JALR;
                14:     op = T_AUIPC;
                15:     op = T_LUI;
                16: begin
                    op = 7'($urandom_range(0, 127));
                    while (legal_op(op)) op = 7'($urandom_range(0, 127));
                end
                default: op = T_R;
            endcase
            run_instr(op, f3, pick_wait(), pick_wait(),
                      $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, tr);
            if (tr) recover();
        end

        cur_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, register file, PC and unified memory port through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit ALUOp consumed by the ALU decoder, plus a funct3 override so AUIPC/LUI reach the decoder's ALUOp=11 sub-cases.
- Handles memory wait states and traps on illegal opcodes and memory timeouts.

Parameters:
- STATE_W, 4: width of state register.
- MAX_WAIT, 16: max cycles spent waiting for mem_ready in one state before a timeout trap. 0 disables the watchdog.
- WAIT_W, 5: width of wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- op  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- adr_src  out  1  0 = PC, 1 = ALUOut to the memory address.
- mem_write  out  1  store strobe.
- ir_write  out  1  IR/oldPC load.
- reg_write  out  1  regfile write.
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4.
- alu_op  out  2  to the ALU decoder.
- imm_src  out  3  I=000, S=001, B=010, J=011, U=100.
- f3_force_en  out  1  datapath replaces funct3 with f3_force at the decoder input.
- f3_force  out  3  forced funct3 value.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky; 1 = halted.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to FETCH; wait counter = 0; trap = 0; trap_cause = 00.
  - While reset is high, all strobes (pc_write, ir_write, mem_write, reg_write, retire) are 0.
  - Reset mid-instruction or mid-wait abandons the instruction; no partial strobe is allowed.
- Output timing:
  - Outputs are Moore-decoded from the state.
  - Exceptions: pc_write, ir_write and mem_write are qualified by mem_ready or zero where noted below.
  - Any output not listed for a state is 0.
- imm_src is decoded combinationally from op in every state. Unknown op gives 000.
- States and transitions:
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write equal mem_ready. Go to DECODE when mem_ready=1, else stay.
  - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0010111 → AUIPC
    - 0110111 → LUI
    - anything else → TRAP, cause 01
  - MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1. Go to MEMWB on mem_ready.
  - MEMWB: result_src=01, reg_write=1, retire=1. Go to FETCH.
  - MEMWRITE: adr_src=1, mem_write=1, held until mem_ready. On mem_ready, retire=1 and go to FETCH.
  - EXEC_R: a=10, b=00, alu_op=10. Go to ALUWB.
  - EXEC_I: a=10, b=01, alu_op=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1, retire=1. Go to FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00. Only funct3 000 (beq) and 001 (bne) are legal.
    - pc_write = (f3=000 & zero) | (f3=001 & ~zero).
    - retire=1; go to FETCH.
    - Other funct3 → TRAP, cause 01, with no pc_write.
  - JALR: a=10, b=01, alu_op=00 (target into ALUOut). Go to JAL.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB; rd gets oldPC+4.
  - AUIPC: a=01, b=01, alu_op=11, f3_force_en=1, f3_force=000. Go to ALUWB.
  - LUI: a=01, b=01, alu_op=11, f3_force_en=1, f3_force=001. Go to ALUWB.
  - TRAP: all strobes 0; trap=1. Stays in TRAP until reset.
- Wait watchdog:
  - Counter clears on every state change.
  - Counter increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0.
  - If MAX_WAIT≠0 and the counter reaches MAX_WAIT with mem_ready still 0, go to TRAP with cause 10.
  - mem_ready arriving on that same cycle wins: normal transition, no trap.
- Counter saturates and never wraps.

Decomposition:
- Package ctrl_pkg:
  - state enum encodings
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI)
  - ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_U=11
  - IMM_* codes, SRCA_*/SRCB_*/RES_* codes, TRAP_* codes
- Sub-module imm_src_decoder: pure combinational op → imm_src.
- The FSM, watchdog and output decode stay in the top module.

Test Plan:
- add x3,x1,x2 with mem_ready=1:
  - states FETCH, DECODE, EXEC_R, ALUWB (4 cycles)
  - alu_op=10 in EXEC_R; reg_write and retire only in ALUWB.
- lw with mem_ready low for 3 cycles in MEMREAD:
  - adr_src held at 1 for 4 cycles
  - MEMWB follows with result_src=01 and reg_write=1
  - total 8 cycles.
- beq, zero=1 vs zero=0:
  - pc_write=1 vs 0 in BRANCH, alu_op=01
  - funct3=100 → trap=1, trap_cause=01, no pc_write.
- lui then auipc:
  - alu_op=11 with f3_force_en=1, f3_force=001 then 000
  - jalr: JALR→JAL→ALUWB with pc_write=1 only in JAL.
- MAX_WAIT=16, mem_ready held 0 in FETCH:
  - trap, cause 10, after 16 wait cycles
  - mem_ready=1 on cycle 16 → DECODE, no trap.
- Reset asserted in MEMWRITE with mem_write=1:
  - next cycle state=FETCH, mem_write=0
  - trap cleared; op=0000000 → TRAP, cause 01.
